sort_frame_sequencer: RTL and testbench
=======================================

Name: sort_frame_sequencer

Overview:
- Sequences the team's 8-lane, 8-bit registered bitonic sort network.
- Collects a frame of up to 8 bytes from a valid/ready input stream and pads unused lanes.
- Presents the frame to the sorter, waits a fixed latency, captures the sorted vector, and streams it out in order with a last flag.
- Sits between a byte-stream producer and the sorter instance; the sorter is instantiated alongside it, not inside it.

Parameters:
- DW, 8: element width in bits. Must match the sorter lane width.
- LANES, 8: sorter lane count. Fixed at 8; other values are unsupported.
- SORT_LAT, 1: clock edges from a stable sorter input to a valid sorter output. Range 1..15.
- PAD, 8'hFF: fill value for unused lanes in ascending mode.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input element valid
- in_ready  out  1  sequencer can accept an element
- in_data  in  DW  input element
- in_last  in  1  final element of a partial frame; ignored unless in_valid && in_ready
- sort_data_o  out  LANES*DW  lanes to the sorter; lane i at bits [DW*i+DW-1 : DW*i]
- sort_data_i  in  LANES*DW  sorted lanes from the sorter; lane 0 is smallest
- out_valid  out  1  output element valid
- out_ready  in  1  consumer accepts the element
- out_data  out  DW  sorted output element
- out_last  out  1  marks the final element of the frame
- busy  out  1  a frame is in progress

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - rst is asynchronous and active-high.
  - All state is cleared immediately on rst assertion.
- Reset values:
  - state = LOAD, element count = 0, in_ready = 1.
  - out_valid = 0, out_data = 0, out_last = 0, busy = 0.
  - sort_data_o = all zeros.
- States: LOAD, WAIT, UNLOAD.
- LOAD:
  - in_ready = 1.
  - On each handshake (in_valid && in_ready), write in_data to buffer lane cnt, then increment cnt.
  - Close the frame on the handshake of the 8th element, or on any handshake with in_last = 1.
  - At close: store n = cnt+1, write PAD into lanes cnt+1..7 on the same edge, go to WAIT.
  - in_last on the 8th element behaves the same as a full frame.
- sort_data_o:
  - Driven directly from the buffer registers.
  - Stable from the first WAIT cycle until the next frame starts loading.
- WAIT:
  - in_ready = 0.
  - A wait counter runs from the entry edge.
  - At the SORT_LAT+1-th edge after the closing handshake, capture sort_data_i into the result register and go to UNLOAD.
- UNLOAD:
  - in_ready = 0, out_valid = 1.
  - out_data = result[idx], starting at idx = 0.
  - out_last = (idx == n-1).
  - On out_valid && out_ready: increment idx.
  - On the handshake with out_last = 1: go to LOAD with cnt = 0 and idx = 0; out_valid falls on the same edge.
- Backpressure: out_data and out_last stay stable while out_valid && !out_ready.
- Latency (SORT_LAT = 1): out_valid rises 2 edges after the closing input handshake. In general it rises SORT_LAT+1 edges after it.
- Throughput: the next frame's first handshake can occur at the earliest in the cycle after the last output handshake. There is no overlap between frames.
- busy = (state != LOAD) || (cnt != 0).
- Ties and PAD: real elements equal to PAD are indistinguishable from padding. Emitting the first n sorted lanes is still correct.
- rst during any state aborts the frame. Partial input and pending output are discarded with no further output beats.
- Inputs are ignored outside LOAD; no element is ever accepted while in_ready = 0.

Optional Feature:
- Macro: SORT_FRAME_DESC_EN.
- When defined:
  - Unused lanes are padded with 0 instead of PAD.
  - UNLOAD emits result[7] down to result[8-n], giving descending order.
  - out_last is asserted on result[8-n].
- When undefined: ascending order with PAD fill, as described in Behaviour.
- Latency and handshake are identical in both modes.

Test Plan:
- Full frame 05,03,08,01,07,02,06,04 with out_ready = 1 → out_data 01..08 on consecutive cycles. out_last only with 08. out_valid rises 2 edges after the 8th input handshake.
- Partial frame 09,20,04 with in_last on 04 → exactly 3 beats: 04,09,20, out_last on 20. sort_data_o lanes 3..7 = FF.
- Partial frame FF,FF,01 with in_last → beats 01,FF,FF; exactly 3 beats, out_last on the third.
- Backpressure: out_ready toggled 1,0,0,1,0,1… on the first frame → each value is held while stalled, and the output sequence is unchanged with no drops or duplicates.
- in_valid held high throughout WAIT and UNLOAD → in_ready = 0 and nothing accepted. Next frame's first element is accepted the cycle after out_last's handshake.
- rst pulse after 2 output beats → all outputs return to reset values immediately. A following frame 02,01 with in_last → beats 01,02.

Source files
------------

// File: rtl/sort_frame_sequencer.sv
// Frame sequencer for the external 8-lane registered bitonic sorter: gathers up to 8 bytes, pads,
// waits SORT_LAT edges, captures the sorted lanes and streams them out. Optional macro: SORT_FRAME_DESC_EN.
module sort_frame_sequencer #(
  parameter int              DW       = 8,
  parameter int              LANES    = 8,
  parameter int              SORT_LAT = 1,
  parameter logic [DW-1:0]   PAD      = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DW-1:0]         in_data,
  input  logic                  in_last,
  output logic [LANES*DW-1:0]   sort_data_o,
  input  logic [LANES*DW-1:0]   sort_data_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DW-1:0]         out_data,
  output logic                  out_last,
  output logic                  busy
);

  localparam int CW = $clog2(LANES);
  localparam int WW = 4;

`ifdef SORT_FRAME_DESC_EN
  localparam bit            DESC = 1'b1;
  localparam logic [DW-1:0] FILL = '0;
`else
  localparam bit            DESC = 1'b0;
  localparam logic [DW-1:0] FILL = PAD;
`endif

  typedef enum logic [1:0] {
    S_LOAD,
    S_WAIT,
    S_UNLOAD
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [CW:0]     n;
  logic [CW-1:0]   idx;
  logic [CW-1:0]   sel;
  logic [WW-1:0]   wcnt;
  logic [DW-1:0]   buffer [LANES];
  logic [DW-1:0]   result [LANES];

  logic            in_hs;
  logic            close;
  logic            wait_done;
  logic            out_hs;
  logic            last_beat;

  assign in_hs     = (state == S_LOAD) && in_valid;
  assign close     = in_hs && (in_last || (cnt == CW'(LANES - 1)));
  assign wait_done = (state == S_WAIT) && (wcnt == WW'(SORT_LAT));
  assign out_hs    = (state == S_UNLOAD) && out_ready;
  assign last_beat = (state == S_UNLOAD) && ({1'b0, idx} == (n - (CW+1)'(1)));
  assign busy      = (state != S_LOAD) || (cnt != '0);

  // Descending mode walks the result from the top lane down; last beat is still beat n-1.
  assign sel = DESC ? (CW'(LANES - 1) - idx) : idx;

  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_lanes
      assign sort_data_o[DW*g +: DW] = buffer[g];
    end
  endgenerate

  // NOTE: sequential state uses <= so every register samples pre-edge values; = here would race.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output; a missed branch would infer a latch.
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    case (state)
      S_LOAD: begin
        in_ready = 1'b1;
        if (close) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_done) begin
          state_nxt = S_UNLOAD;
        end
      end
      S_UNLOAD: begin
        out_valid = 1'b1;
        out_data  = result[sel];
        out_last  = last_beat;
        if (out_ready && last_beat) begin
          state_nxt = S_LOAD;
        end
      end
      default: begin
        state_nxt = S_LOAD;
      end
    endcase
  end

  // Element counter and frame length; cnt restarts at close so the next frame loads from lane 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      n   <= '0;
    end else if (in_hs) begin
      if (close) begin
        n   <= {1'b0, cnt} + (CW+1)'(1);
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // NOTE: the buffer drives sort_data_o directly, which must read zero after reset, so this memory is reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) begin
        buffer[i] <= '0;
      end
    end else if (in_hs) begin
      for (int i = 0; i < LANES; i++) begin
        if (CW'(i) == cnt) begin
          buffer[i] <= in_data;
        end else if (close && (CW'(i) > cnt)) begin
          buffer[i] <= FILL;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt <= '0;
    end else if (close) begin
      wcnt <= '0;
    end else if (state == S_WAIT) begin
      wcnt <= wcnt + WW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) begin
        result[i] <= '0;
      end
    end else if (wait_done) begin
      for (int i = 0; i < LANES; i++) begin
        result[i] <= sort_data_i[DW*i +: DW];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (out_hs) begin
      if (last_beat) begin
        idx <= '0;
      end else begin
        idx <= idx + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sort_frame_sequencer.sv
// Scoreboard bench for sort_frame_sequencer with a behavioural registered sorter beside the DUT.
module tb_sort_frame_sequencer;

  localparam int          DW       = 8;
  localparam int          LANES    = 8;
  localparam int          SORT_LAT = 1;
  localparam logic [7:0]  PAD      = 8'hFF;
`ifdef SORT_FRAME_DESC_EN
  localparam logic [7:0]  FILL     = 8'h00;
`else
  localparam logic [7:0]  FILL     = PAD;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic [63:0] sort_data_o;
  logic [63:0] sort_data_i;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        busy;

  sort_frame_sequencer #(
    .DW(DW), .LANES(LANES), .SORT_LAT(SORT_LAT), .PAD(PAD)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .sort_data_o(sort_data_o), .sort_data_i(sort_data_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    beats_done = 0;
  int    close_edge = 0;
  int    last_out_edge = 0;
  int    rdy_mode = 0;
  bit    prev_valid = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] sort_lanes(input logic [63:0] v);
    logic [7:0]  q[$];
    logic [63:0] r;
    for (int i = 0; i < 8; i++) q.push_back(v[8*i +: 8]);
    q.sort();
    r = '0;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = q[i];
    return r;
  endfunction

  // Behavioural stand-in for the registered sorter: SORT_LAT edges from input to sorted output.
  logic [63:0] pipe [SORT_LAT];
  always @(posedge clk) begin
    pipe[0] <= sort_lanes(sort_data_o);
    for (int i = 1; i < SORT_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign sort_data_i = pipe[SORT_LAT-1];

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: out_ready = (((cyc % 6) == 0) || ((cyc % 6) == 3) || ((cyc % 6) == 5));
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: compares every presented beat with the scoreboard head, pops on handshake.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (!prev_valid) check("latency", cyc - close_edge, SORT_LAT + 1);
      check("in_ready_busy_unload", {in_ready, busy}, 2'b01);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got data %0h with no beat expected", out_data);
      end else begin
        check("out_data", out_data, exp_q[0].data);
        check("out_last", out_last, exp_q[0].last);
        if (out_ready) begin
          void'(exp_q.pop_front());
          beats_done++;
          if (out_last) last_out_edge = cyc + 1;
        end
      end
    end
    prev_valid = out_valid;
  end

  task automatic send_elem(input logic [7:0] d, input logic l, output int hs_edge);
    int  t;
    bit  got;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    t = 0;
    got = 1'b0;
    hs_edge = -1;
    while (!got && t < 400) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      else t++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no in_ready expected acceptance of %0h", d);
    end else begin
      hs_edge = cyc + 1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d[$], input bit hold, input bit chk_b2b);
    int          n;
    int          e;
    logic        lst;
    logic [7:0]  m[$];
    logic [63:0] ev;
    beat_t       b;
    n = d.size();
    for (int i = 0; i < n; i++) begin
      if (i > 0 && !hold && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'($urandom);
        @(posedge clk);
        #1;
      end
      lst = 1'b0;
      if (i == n - 1) lst = (n < 8) ? 1'b1 : 1'($urandom_range(0, 1));
      send_elem(d[i], lst, e);
      if (i == 0 && chk_b2b) check("next_frame_first_accept", e, last_out_edge + 1);
      if (i == n - 1) close_edge = e;
    end
    in_last = 1'b0;
    if (!hold) in_valid = 1'b0;
    m = d;
`ifdef SORT_FRAME_DESC_EN
    m.rsort();
`else
    m.sort();
`endif
    for (int i = 0; i < n; i++) begin
      b.data = m[i];
      b.last = (i == n - 1);
      exp_q.push_back(b);
    end
    ev = '0;
    for (int i = 0; i < 8; i++) ev[8*i +: 8] = (i < n) ? d[i] : FILL;
    check("sort_data_o", sort_data_o, ev);
    check("busy_after_close", {busy, in_ready}, 2'b10);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("drain_pending", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, {in_ready, out_valid, out_last, busy}, 4'b1000);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_sort_data_o"}, sort_data_o, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] f[$];
    int         base;
    int         t;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    #3;
    check_reset_outputs("reset");
    #9;
    rst = 1'b0;
    @(posedge clk);
    #1;

    f = {8'h05, 8'h03, 8'h08, 8'h01, 8'h07, 8'h02, 8'h06, 8'h04};
    send_frame(f, 1'b0, 1'b0);
    wait_idle();

    f = {8'h09, 8'h20, 8'h04};
    send_frame(f, 1'b0, 1'b0);
    wait_idle();

    f = {8'hFF, 8'hFF, 8'h01};
    send_frame(f, 1'b0, 1'b0);
    wait_idle();

    rdy_mode = 1;
    f = {8'h05, 8'h03, 8'h08, 8'h01, 8'h07, 8'h02, 8'h06, 8'h04};
    send_frame(f, 1'b0, 1'b0);
    wait_idle();
    rdy_mode = 0;

    f = {8'h33, 8'h11, 8'h22};
    send_frame(f, 1'b1, 1'b0);
    f = {8'h44, 8'h40, 8'h7E, 8'h00, 8'h90};
    send_frame(f, 1'b1, 1'b1);
    in_valid = 1'b0;
    wait_idle();

    f = {8'h15, 8'hA0, 8'h3C, 8'h07, 8'h99, 8'h42, 8'h61, 8'h10};
    base = beats_done;
    send_frame(f, 1'b0, 1'b0);
    t = 0;
    while (beats_done < base + 2 && t < 100) begin
      @(posedge clk);
      t++;
    end
    check("beats_before_reset", beats_done - base, 2);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    exp_q.delete();
    @(negedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    f = {8'h02, 8'h01};
    send_frame(f, 1'b0, 1'b0);
    wait_idle();

    rdy_mode = 2;
    repeat (40) begin
      int n;
      n = $urandom_range(1, 8);
      f.delete();
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) f.push_back(8'hFF);
        else f.push_back(8'($urandom_range(0, 255)));
      end
      send_frame(f, 1'b0, 1'b0);
    end
    wait_idle();
    rdy_mode = 0;
    check("final_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
